hazard_ctrl: RTL and testbench

//   Pipeline hazard/stall controller for the 5-stage forwarding core. Drives the en/flush

---
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Stall/flush controller for the 5-stage forwarding core. It drives the PC
//   enable and the en/flush controls of IF_ID, ID_EX, EX_MEM and MEM_WB. It
//   handles three situations:
//     - Load-use hazards: a single bubble is inserted into EX.
//     - Taken branches: IF_ID and ID_EX are squashed.
//     - Data-memory wait states: the whole pipeline is frozen.
//   A sticky watchdog flags a memory access that stays busy for too long.
//   Every en/flush output is combinational from the state and the inputs.
//
// Parameters
//   MEM_TIMEOUT  number of busy cycles before mem_timeout sets (1..65535)
//   CNT_W        width of the wait counter; must be able to hold MEM_TIMEOUT
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   id_rs1, id_rs2               source registers of the instruction in ID
//   id_rs1_used, id_rs2_used     the ID instruction actually reads rs1 / rs2
//   ex_mem_read, ex_rd           the instruction in EX is a load, and its destination
//   ex_branch_taken              a branch/jump resolved taken in EX this cycle
//   mem_busy                     data memory not ready; the MEM access must hold
//   pc_en, *_en                  PC and pipeline-register enables
//   if_id_flush, id_ex_flush     load a bubble into IF_ID / ID_EX on the next edge
//   mem_timeout                  sticky watchdog flag, cleared only by rst
//
// Optional build macro PIPE_CTRL_PERF_EN
//   When defined, the block gains two 32-bit wrapping counters:
//     perf_stall_cnt  counts cycles with pc_en=0
//     perf_flush_cnt  counts cycles with if_id_flush=1
//   Both are cleared by rst and do not count while rst is high.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             load_use;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = ST_RUN;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (rst) begin
            // While reset is asserted, the datapath runs freely with no stalls
            // or flushes, so the defaults above are kept.
            state_d = ST_RUN;
        end else if (mem_busy) begin
            // Freeze everything. A pending branch or hazard stays in the frozen
            // registers and is seen again once memory is ready.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            state_d   = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use hazard it has is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_RUN;
        end else if (load_use && (state_q != ST_LU_STALL)) begin
            // Hold PC and IF_ID, and push a bubble into EX. In the following
            // cycle the load has reached MEM and forwarding covers the rest,
            // so the hazard is masked while in LU_STALL.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            state_d     = ST_LU_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    // The busy cycle that enters MEM_WAIT counts as the first wait cycle, so
    // mem_timeout rises on the edge that ends the MEM_TIMEOUT-th busy cycle.
    // Any ready cycle leaves MEM_WAIT and clears the count.
    always_comb begin
        wait_cnt_d = '0;
        if (mem_busy) begin
            if (wait_cnt_q == TIMEOUT_VAL) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
        timeout_d = timeout_q || (mem_busy && (wait_cnt_d == TIMEOUT_VAL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, ~pc_en};
            perf_flush_q <= perf_flush_q + {31'd0, if_id_flush};
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned MT = 4;

    // Output vector layout:
    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_timeout}
    localparam logic [7:0] ALL    = 8'b11111_00_0;
    localparam logic [7:0] STALL  = 8'b00111_01_0;
    localparam logic [7:0] FREEZE = 8'b00000_00_0;
    localparam logic [7:0] FLUSH  = 8'b11111_11_0;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, mem_busy;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .mem_timeout(mem_timeout)
    );

    wire [7:0] act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                      if_id_flush, id_ex_flush, mem_timeout};

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       busy;
        logic [7:0] exp;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    // The model tracks three things:
    //   - whether the previous cycle was a load-use stall (the hazard is then
    //     already resolved by forwarding);
    //   - how many consecutive busy cycles have been seen;
    //   - the sticky timeout flag.
    logic    m_prev_lu_stall = 1'b0;
    int      m_busy_run      = 0;
    logic    m_to            = 1'b0;
    longint  m_stall_cnt     = 0;
    longint  m_flush_cnt     = 0;

    function automatic logic model_hazard();
        return ex_mem_read && ex_rd != 0 &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    endfunction

    function automatic logic [7:0] model_out();
        logic [7:0] o;
        if (rst)                                     o = ALL;
        else if (mem_busy)                           o = FREEZE;
        else if (ex_branch_taken)                    o = FLUSH;
        else if (model_hazard() && !m_prev_lu_stall) o = STALL;
        else                                         o = ALL;
        o[0] = m_to;
        return o;
    endfunction

    always @(posedge clk) begin
        logic [7:0] o;
        o = model_out();
        if (rst) begin
            m_prev_lu_stall <= 1'b0;
            m_busy_run      <= 0;
            m_to            <= 1'b0;
            m_stall_cnt     <= 0;
            m_flush_cnt     <= 0;
        end else begin
            m_prev_lu_stall <= !mem_busy && !ex_branch_taken && model_hazard() && !m_prev_lu_stall;
            m_busy_run      <= mem_busy ? m_busy_run + 1 : 0;
            if (mem_busy && m_busy_run + 1 >= int'(MT)) m_to <= 1'b1;
            m_stall_cnt     <= (m_stall_cnt + (o[7] ? 0 : 1)) % 64'h1_0000_0000;
            m_flush_cnt     <= (m_flush_cnt + (o[2] ? 1 : 0)) % 64'h1_0000_0000;
        end
    end

    // ---------------- helpers ----------------
    task automatic cmp8(input string nm, input logic [7:0] a, input logic [7:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %b required %b", nm, a, e);
    endtask

    task automatic cmp32(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0d required %0d", nm, a, e);
    endtask

    function automatic vec_t mk(logic r, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                                logic u2, logic mr, logic [4:0] rd, logic br,
                                logic busy, logic [7:0] e);
        vec_t v;
        v.rst = r;  v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.mr = mr;  v.rd = rd;   v.br = br; v.busy = busy; v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; id_rs1 = v.rs1; id_rs1_used = v.u1; id_rs2 = v.rs2;
        id_rs2_used = v.u2; ex_mem_read = v.mr; ex_rd = v.rd;
        ex_branch_taken = v.br; mem_busy = v.busy;
    endtask

    // Drive one cycle, sample on the falling edge, then advance past the rising edge.
    task automatic step(input vec_t v, input string nm, input bit use_model);
        drive(v);
        @(negedge clk);
        cmp8(nm, act, use_model ? model_out() : v.exp);
`ifdef PIPE_CTRL_PERF_EN
        cmp32({nm, ".stall_cnt"}, perf_stall_cnt, m_stall_cnt[31:0]);
        cmp32({nm, ".flush_cnt"}, perf_flush_cnt, m_flush_cnt[31:0]);
`endif
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[21];
    vec_t v;

    initial begin
        // Vector table: rst, rs1, u1, rs2, u2, mr, rd, br, busy, expected
        tbl[0]  = mk(1, 5,1, 0,0, 1,5, 0,1, ALL);    // rst overrides busy and hazard
        tbl[1]  = mk(0, 1,1, 2,1, 0,0, 0,0, ALL);
        tbl[2]  = mk(0, 5,1, 0,0, 1,5, 0,0, STALL);  // load x5, rs1=5
        tbl[3]  = mk(0, 5,1, 0,0, 1,5, 0,0, ALL);    // one bubble only
        tbl[4]  = mk(0, 0,1, 0,0, 1,0, 0,0, ALL);    // x0 never hazards
        tbl[5]  = mk(0, 3,1, 7,0, 1,7, 0,0, ALL);    // rs2 matches but unused
        tbl[6]  = mk(0, 3,1, 7,1, 1,7, 0,0, STALL);  // rs2 hazard
        tbl[7]  = mk(0, 3,1, 7,1, 1,7, 0,0, ALL);
        tbl[8]  = mk(0, 7,1, 0,0, 1,7, 1,0, FLUSH);  // branch beats load-use
        tbl[9]  = mk(0, 7,1, 0,0, 1,7, 0,0, STALL);  // back in RUN after branch
        tbl[10] = mk(0, 0,0, 0,0, 0,0, 0,1, FREEZE);
        tbl[11] = mk(0, 0,0, 0,0, 0,0, 0,1, FREEZE);
        tbl[12] = mk(0, 0,0, 0,0, 0,0, 0,1, FREEZE);
        tbl[13] = mk(0, 0,0, 0,0, 0,0, 0,0, ALL);    // resume, no timeout after 3
        tbl[14] = mk(0, 7,1, 0,0, 1,7, 1,1, FREEZE); // freeze beats branch
        tbl[15] = mk(0, 7,1, 0,0, 1,7, 1,0, FLUSH);
        tbl[16] = mk(0, 7,1, 0,0, 1,7, 0,0, STALL);
        tbl[17] = mk(0, 7,1, 0,0, 1,7, 0,1, FREEZE); // busy during LU_STALL
        tbl[18] = mk(0, 7,1, 0,0, 1,7, 0,0, STALL);  // hazard re-evaluated after wait
        tbl[19] = mk(0, 4,1, 9,1, 0,9, 0,0, ALL);    // not a load
        tbl[20] = mk(0, 4,1, 8,1, 1,9, 0,0, ALL);    // load, no register match

        drive(mk(1, 0,0, 0,0, 0,0, 0,0, ALL));
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) step(tbl[i], $sformatf("vec%0d", i), 1'b0);

        // Watchdog: mem_busy held 10 cycles; the flag appears after the 4th busy cycle.
        for (int k = 0; k < 10; k++) begin
            v = mk(0, 0,0, 0,0, 0,0, 0,1, FREEZE | {7'd0, (k >= int'(MT))});
            step(v, $sformatf("busy%0d", k), 1'b0);
        end
        for (int k = 0; k < 2; k++) step(mk(0, 0,0, 0,0, 0,0, 0,0, ALL | 8'd1), "to_sticky", 1'b0);
        step(mk(1, 0,0, 0,0, 0,0, 0,0, ALL | 8'd1), "to_in_rst", 1'b0);
        step(mk(0, 0,0, 0,0, 0,0, 0,0, ALL), "to_cleared", 1'b0);

        // Reset arriving during LU_STALL.
        step(mk(0, 6,1, 0,0, 1,6, 0,0, STALL), "lu_pre_rst", 1'b0);
        step(mk(1, 6,1, 0,0, 1,6, 0,0, ALL),   "lu_in_rst", 1'b0);
        drive(mk(0, 0,0, 0,0, 0,0, 0,0, ALL));
        @(negedge clk);
        cmp8("lu_after_rst", act, ALL);
`ifdef PIPE_CTRL_PERF_EN
        cmp32("perf_stall_zero", perf_stall_cnt, 32'd0);
        cmp32("perf_flush_zero", perf_flush_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        step(mk(0, 6,1, 0,0, 1,6, 0,0, STALL), "lu_run_after_rst", 1'b0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            v.rst  = ($urandom_range(0, 29) == 0);
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.rd   = 5'($urandom_range(0, 3));
            v.u1   = 1'($urandom_range(0, 1));
            v.u2   = 1'($urandom_range(0, 1));
            v.mr   = ($urandom_range(0, 2) != 0);
            v.br   = ($urandom_range(0, 5) == 0);
            v.busy = ($urandom_range(0, 7) < 3);
            v.exp  = 8'h00;
            step(v, $sformatf("rand%0d", i), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
